prog_data_mem: RTL and testbench

//  Parametrised single-array program/data memory for the multicycle core. On reset it clears the array,

---
 rtl/prog_data_mem_pkg.sv | 11 +
 rtl/mem_arb2.sv | 23 ++
 rtl/prog_data_mem.sv | 121 ++++++++++++
 tb/tb_prog_data_mem.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_data_mem_pkg.sv
// prog_data_mem_pkg: shared types and helpers for the boot-loadable program/data memory
package prog_data_mem_pkg;
  typedef enum logic [1:0] {CLEAR, BOOT, RUN} state_t;
  localparam int LANE_W = 8;
  function automatic int lanes(input int w);
    return w / LANE_W;
  endfunction
  function automatic bit width_ok(input int w);
    return w > 0 && w % LANE_W == 0;
  endfunction
endpackage

// File: rtl/mem_arb2.sv
// mem_arb2: fixed-priority two-requester arbiter (req[0] wins) with registered grant index
module mem_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic [1:0] done
);
  logic v_q;
  logic idx_q;
  assign gnt  = {en & req[1] & ~req[0], en & req[0]};
  assign done = {v_q & idx_q, v_q & ~idx_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= 1'b0;
      idx_q <= 1'b0;
    end else begin
      v_q   <= |gnt;
      idx_q <= gnt[1];
    end
  end
endmodule

// File: rtl/prog_data_mem.sv
// prog_data_mem: clear-then-boot memory serving a fetch port and a higher-priority data port
module prog_data_mem
  import prog_data_mem_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 6,
  parameter int DEPTH          = 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      proc_rst,
  input  logic                      boot_valid,
  input  logic                      boot_last,
  input  logic [ADDR_W-1:0]         boot_addr,
  input  logic [DATA_W-1:0]         boot_data,
  output logic                      boot_ready,
  output logic                      mem_ready,
  input  logic                      if_req,
  input  logic [ADDR_W-1:0]         if_addr,
  output logic                      if_gnt,
  output logic                      if_rvalid,
  output logic [DATA_W-1:0]         if_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [lanes(DATA_W)-1:0]  d_be,
  input  logic [ADDR_W-1:0]         d_addr,
  input  logic [DATA_W-1:0]         d_wdata,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [DATA_W-1:0]         d_rdata,
  output logic                      addr_err
);
  localparam int NB = lanes(DATA_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  if (!width_ok(DATA_W)) begin : g_bad_width
    $error("DATA_W must be a positive multiple of 8");
  end
  if (DEPTH > 2 ** ADDR_W) begin : g_bad_depth
    $error("DEPTH exceeds the address space");
  end
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction
  state_t state;
  state_t state_n;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [NB-1:0] we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic run;
  logic rd_q;
  logic [1:0] gnt;
  logic [1:0] done;
  assign run        = state == RUN && !proc_rst;
  assign boot_ready = state == BOOT;
  assign mem_ready  = state == RUN;
  assign d_gnt      = gnt[0];
  assign if_gnt     = gnt[1];
  assign if_rvalid  = done[1];
  assign d_rvalid   = done[0] & rd_q;
  mem_arb2 u_arb (
    .clk  (clk),
    .rst  (proc_rst),
    .en   (run),
    .req  ({if_req, d_req}),
    .gnt  (gnt),
    .done (done)
  );
  always_comb begin
    state_n = state == CLEAR ? (cnt == LAST ? BOOT : CLEAR)
            : state == BOOT  ? (boot_valid && boot_last ? RUN : BOOT)
            : RUN;
  end
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : BOOT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= state == CLEAR ? cnt + 1'b1 : cnt;
    end
  end
  // one write port shared by clear, boot and data writes; the state selects the source
  always_comb begin
    we = '0;
    wa = cnt;
    wd = '0;
    if (proc_rst) begin
      we = '0;
    end else if (state == CLEAR) begin
      we = '1;
    end else if (state == BOOT) begin
      we = {NB{boot_valid && in_range(boot_addr)}};
      wa = boot_addr;
      wd = boot_data;
    end else begin
      we = gnt[0] && d_we && in_range(d_addr) ? d_be : '0;
      wa = d_addr;
      wd = d_wdata;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (we[i]) mem[wa][i*8+:8] <= wd[i*8+:8];
  end
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      if_rdata <= '0;
      d_rdata  <= '0;
      rd_q     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (gnt[0] && !d_we) d_rdata <= in_range(d_addr) ? mem[d_addr] : '0;
      if (gnt[1]) if_rdata <= in_range(if_addr) ? mem[if_addr] : '0;
      rd_q     <= !d_we;
      addr_err <= (gnt[0] && !in_range(d_addr)) || (gnt[1] && !in_range(if_addr));
    end
  end
endmodule

// File: tb/tb_prog_data_mem.sv
// tb_prog_data_mem: randomized model-checked bench for prog_data_mem (64-word and 48-word instances)
module tb_prog_data_mem;
  localparam int DEP = 64;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic proc_rst, boot_valid, boot_last, boot_ready, mem_ready;
  logic [5:0] boot_addr, if_addr, d_addr;
  logic [15:0] boot_data, if_rdata, d_wdata, d_rdata;
  logic if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid, addr_err;
  logic [1:0] d_be;
  logic b_rst, b_bv, b_bl, b_boot_ready, b_mem_ready;
  logic [5:0] b_ba, b_ia, b_da;
  logic [15:0] b_bd, b_if_rdata, b_dwd, b_d_rdata;
  logic b_ir, b_if_gnt, b_if_rvalid, b_dr, b_dw, b_d_gnt, b_d_rvalid, b_addr_err;
  logic [1:0] b_dbe;
  prog_data_mem #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .proc_rst(proc_rst), .boot_valid(boot_valid), .boot_last(boot_last),
    .boot_addr(boot_addr), .boot_data(boot_data), .boot_ready(boot_ready), .mem_ready(mem_ready),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .addr_err(addr_err)
  );
  prog_data_mem #(.DATA_W(16), .ADDR_W(6), .DEPTH(48), .CLEAR_ON_RESET(1'b1)) dut48 (
    .clk(clk), .proc_rst(b_rst), .boot_valid(b_bv), .boot_last(b_bl),
    .boot_addr(b_ba), .boot_data(b_bd), .boot_ready(b_boot_ready), .mem_ready(b_mem_ready),
    .if_req(b_ir), .if_addr(b_ia), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_dr), .d_we(b_dw), .d_be(b_dbe), .d_addr(b_da), .d_wdata(b_dwd), .d_gnt(b_d_gnt),
    .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .addr_err(b_addr_err)
  );
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] m [DEP];
  logic [15:0] e_if_rd, e_d_rd, o_if_rd, o_d_rd;
  logic [1:0] e_gnt, o_gnt, e_rv, o_rv;
  logic e_err, o_err;
  task automatic model_clear();
    for (int i = 0; i < DEP; i++) m[i] = '0;
    e_if_rd = '0;
    e_d_rd = '0;
  endtask
  task automatic do_reset();
    proc_rst = 1'b1;
    @(posedge clk); #1;
    proc_rst = 1'b0;
  endtask
  task automatic wait_ready(output int n, output logic g);
    n = 0;
    g = 1'b0;
    if_req = 1'b1;
    d_req = 1'b1;
    while (!boot_ready && n < 300) begin
      #1;
      g = g | if_gnt | d_gnt;
      @(posedge clk); #1;
      n++;
    end
    if_req = 1'b0;
    d_req = 1'b0;
  endtask
  // one RUN-mode cycle: drives requests, records observed outputs and the model's expectation
  task automatic bus_cycle(input logic ir, input logic [5:0] ia, input logic dr, input logic dw,
                           input logic [1:0] dbe, input logic [5:0] da, input logic [15:0] dwd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_be = dbe; d_addr = da; d_wdata = dwd;
    #1;
    o_gnt = {if_gnt, d_gnt};
    e_gnt = {ir && !dr, dr};
    @(posedge clk); #1;
    e_rv = {ir && !dr, dr && !dw};
    e_err = 1'b0;
    if (ir && !dr) e_if_rd = m[ia];
    if (dr && !dw) e_d_rd = m[da];
    if (dr && dw) for (int i = 0; i < 2; i++) if (dbe[i]) m[da][i*8+:8] = dwd[i*8+:8];
    o_rv = {if_rvalid, d_rvalid};
    o_if_rd = if_rdata;
    o_d_rd = d_rdata;
    o_err = addr_err;
    if_req = 1'b0;
    d_req = 1'b0;
  endtask
  task automatic test_reset();
    int n;
    logic g;
    do_reset();
    n_chk++;
    if ({boot_ready, mem_ready, if_rvalid, d_rvalid, addr_err, if_rdata, d_rdata} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {boot_ready, mem_ready, if_rvalid, d_rvalid, addr_err, if_rdata, d_rdata});
    else n_pass++;
    wait_ready(n, g);
    n_chk++;
    if (n !== 64) $display("FAIL clear_length: got %0d cycles want 64", n); else n_pass++;
    n_chk++;
    if (g !== 1'b0) $display("FAIL clear_no_grant: got %b want 0", g); else n_pass++;
    model_clear();
  endtask
  task automatic test_boot();
    logic [15:0] w [5];
    for (int i = 0; i < 5; i++) begin
      w[i] = 16'($urandom);
      boot_valid = 1'b1; boot_last = i == 4; boot_addr = 6'(i); boot_data = w[i];
      m[i] = w[i];
      if (i == 4) begin
        n_chk++;
        if ({boot_ready, mem_ready} !== 2'b10) $display("FAIL boot_state: got %b want 10", {boot_ready, mem_ready}); else n_pass++;
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if ({boot_ready, mem_ready} !== 2'b01) $display("FAIL run_entry: got %b want 01", {boot_ready, mem_ready}); else n_pass++;
    boot_valid = 1'b1; boot_last = 1'b1; boot_addr = 6'd0; boot_data = ~w[0];
    for (int i = 1; i <= 5; i++) begin
      bus_cycle(1'b1, 6'(i % 5), 1'b0, 1'b0, 2'b00, 6'd0, 16'd0);
      n_chk++;
      if ({o_gnt, o_rv, o_err, o_if_rd} !== {2'b10, 2'b10, 1'b0, w[i % 5]})
        $display("FAIL boot_fetch[%0d]: got %h want %h", i % 5, {o_gnt, o_rv, o_err, o_if_rd}, {2'b10, 2'b10, 1'b0, w[i % 5]});
      else n_pass++;
    end
    boot_valid = 1'b0; boot_last = 1'b0;
  endtask
  task automatic test_clear_all();
    for (int a = 0; a < DEP; a++) begin
      bus_cycle(1'b0, 6'd0, 1'b1, 1'b0, 2'b00, 6'(a), 16'd0);
      n_chk++;
      if ({o_gnt, o_rv, o_err, o_d_rd} !== {e_gnt, e_rv, e_err, e_d_rd})
        $display("FAIL clear_read[%0d]: got %h want %h", a, {o_gnt, o_rv, o_err, o_d_rd}, {e_gnt, e_rv, e_err, e_d_rd});
      else n_pass++;
    end
  endtask
  task automatic test_byte_lane();
    logic [5:0] a;
    a = 6'($urandom_range(8, 63));
    bus_cycle(1'b0, 6'd0, 1'b1, 1'b1, 2'b11, a, 16'h1234);
    bus_cycle(1'b0, 6'd0, 1'b1, 1'b1, 2'b01, a, 16'hABCD);
    n_chk++;
    if ({o_gnt, o_rv} !== 4'b0100) $display("FAIL write_flags: got %b want 0100", {o_gnt, o_rv}); else n_pass++;
    bus_cycle(1'b0, 6'd0, 1'b1, 1'b0, 2'b00, a, 16'd0);
    n_chk++;
    if ({o_d_rd, o_rv} !== {16'h12CD, 2'b01}) $display("FAIL byte_lane_low: got %h want 12cd/01", {o_d_rd, o_rv}); else n_pass++;
    bus_cycle(1'b0, 6'd0, 1'b1, 1'b1, 2'b00, a, 16'hFFFF);
    bus_cycle(1'b0, 6'd0, 1'b1, 1'b1, 2'b10, a, 16'h5600);
    bus_cycle(1'b0, 6'd0, 1'b1, 1'b0, 2'b00, a, 16'd0);
    n_chk++;
    if (o_d_rd !== e_d_rd || o_d_rd !== 16'h56CD) $display("FAIL byte_lane_high: got %h want 56cd", o_d_rd); else n_pass++;
  endtask
  task automatic test_priority();
    logic [5:0] ia, da;
    ia = 6'($urandom_range(0, 4));
    da = 6'($urandom_range(0, 63));
    for (int c = 0; c < 3; c++) begin
      bus_cycle(1'b1, ia, 1'b1, 1'b0, 2'b00, da, 16'd0);
      n_chk++;
      if ({o_gnt, o_rv, o_d_rd} !== {2'b01, 2'b01, e_d_rd})
        $display("FAIL priority_cycle%0d: got %h want %h", c + 1, {o_gnt, o_rv, o_d_rd}, {2'b01, 2'b01, e_d_rd});
      else n_pass++;
    end
    bus_cycle(1'b1, ia, 1'b0, 1'b0, 2'b00, da, 16'd0);
    n_chk++;
    if ({o_gnt, o_rv, o_if_rd} !== {2'b10, 2'b10, m[ia]})
      $display("FAIL priority_fetch: got %h want %h", {o_gnt, o_rv, o_if_rd}, {2'b10, 2'b10, m[ia]});
    else n_pass++;
    bus_cycle(1'b0, 6'd0, 1'b0, 1'b0, 2'b00, 6'd0, 16'd0);
    n_chk++;
    if ({o_rv, o_if_rd} !== {2'b00, m[ia]}) $display("FAIL rdata_hold: got %h want %h", {o_rv, o_if_rd}, {2'b00, m[ia]}); else n_pass++;
  endtask
  task automatic test_back_to_back();
    logic [5:0] a;
    logic [15:0] v;
    a = 6'($urandom_range(5, 63));
    v = 16'($urandom);
    bus_cycle(1'b0, 6'd0, 1'b1, 1'b1, 2'b11, a, v);
    bus_cycle(1'b0, 6'd0, 1'b1, 1'b0, 2'b00, a, 16'd0);
    n_chk++;
    if ({o_rv, o_d_rd} !== {2'b01, v}) $display("FAIL read_after_write: got %h want %h", {o_rv, o_d_rd}, {2'b01, v}); else n_pass++;
    for (int c = 0; c < 400; c++) begin
      bus_cycle(1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 6'($urandom), 16'($urandom));
      n_chk++;
      if ({o_gnt, o_rv, o_err, o_if_rd, o_d_rd} !== {e_gnt, e_rv, e_err, e_if_rd, e_d_rd})
        $display("FAIL random[%0d]: got %h want %h", c, {o_gnt, o_rv, o_err, o_if_rd, o_d_rd}, {e_gnt, e_rv, e_err, e_if_rd, e_d_rd});
      else n_pass++;
    end
  endtask
  task automatic test_mid_boot_reset();
    int n;
    logic g;
    do_reset();
    wait_ready(n, g);
    model_clear();
    for (int i = 0; i < 2; i++) begin
      boot_valid = 1'b1; boot_last = 1'b0; boot_addr = 6'(7 + i); boot_data = 16'($urandom) | 16'h1;
      @(posedge clk); #1;
    end
    boot_valid = 1'b0;
    do_reset();
    n_chk++;
    if (boot_ready !== 1'b0) $display("FAIL midboot_reset_ready: got %b want 0", boot_ready); else n_pass++;
    wait_ready(n, g);
    n_chk++;
    if (n !== 64) $display("FAIL midboot_clear_length: got %0d cycles want 64", n); else n_pass++;
    boot_valid = 1'b1; boot_last = 1'b1; boot_addr = 6'd0; boot_data = 16'h0F0F;
    m[0] = 16'h0F0F;
    @(posedge clk); #1;
    boot_valid = 1'b0; boot_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_cycle(1'b0, 6'd0, 1'b1, 1'b0, 2'b00, 6'(7 + i), 16'd0);
      n_chk++;
      if ({o_rv, o_d_rd} !== 18'h10000) $display("FAIL midboot_cleared[%0d]: got %h want 10000", 7 + i, {o_rv, o_d_rd}); else n_pass++;
    end
  endtask
  task automatic b_cycle(input logic ir, input logic [5:0] ia, input logic dr, input logic dw, input logic [5:0] da, input logic [15:0] dwd);
    b_ir = ir; b_ia = ia; b_dr = dr; b_dw = dw; b_dbe = 2'b11; b_da = da; b_dwd = dwd;
    @(posedge clk); #1;
    b_ir = 1'b0; b_dr = 1'b0;
  endtask
  task automatic test_out_of_range();
    int n;
    logic [15:0] x;
    x = 16'($urandom) | 16'h8001;
    b_rst = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b0;
    n = 0;
    while (!b_boot_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    if (n !== 48) $display("FAIL d48_clear_length: got %0d cycles want 48", n); else n_pass++;
    b_bv = 1'b1; b_bl = 1'b0; b_ba = 6'd47; b_bd = x;
    @(posedge clk); #1;
    b_bl = 1'b1; b_ba = 6'd50; b_bd = 16'hFFFF;
    @(posedge clk); #1;
    b_bv = 1'b0; b_bl = 1'b0;
    n_chk++;
    if (b_mem_ready !== 1'b1) $display("FAIL d48_run_entry: got %b want 1", b_mem_ready); else n_pass++;
    b_cycle(1'b0, 6'd0, 1'b1, 1'b0, 6'd47, 16'd0);
    n_chk++;
    if ({b_d_rvalid, b_addr_err, b_d_rdata} !== {2'b10, x}) $display("FAIL d48_read47: got %h want %h", {b_d_rvalid, b_addr_err, b_d_rdata}, {2'b10, x}); else n_pass++;
    b_dr = 1'b1; b_dw = 1'b0; b_da = 6'd50;
    #1;
    n_chk++;
    if (b_d_gnt !== 1'b1) $display("FAIL d48_oob_grant: got %b want 1", b_d_gnt); else n_pass++;
    @(posedge clk); #1;
    b_dr = 1'b0;
    n_chk++;
    if ({b_d_rvalid, b_addr_err, b_d_rdata} !== 18'h30000) $display("FAIL d48_oob_read: got %h want 30000", {b_d_rvalid, b_addr_err, b_d_rdata}); else n_pass++;
    b_cycle(1'b0, 6'd0, 1'b1, 1'b1, 6'd50, 16'hFFFF);
    n_chk++;
    if ({b_d_rvalid, b_addr_err} !== 2'b01) $display("FAIL d48_oob_write: got %b want 01", {b_d_rvalid, b_addr_err}); else n_pass++;
    b_cycle(1'b0, 6'd0, 1'b1, 1'b0, 6'd47, 16'd0);
    n_chk++;
    if ({b_d_rvalid, b_addr_err, b_d_rdata} !== {2'b10, x}) $display("FAIL d48_unchanged47: got %h want %h", {b_d_rvalid, b_addr_err, b_d_rdata}, {2'b10, x}); else n_pass++;
    b_cycle(1'b0, 6'd0, 1'b1, 1'b0, 6'd2, 16'd0);
    b_cycle(1'b0, 6'd0, 1'b1, 1'b0, 6'd18, 16'd0);
    n_chk++;
    if ({b_d_rvalid, b_addr_err, b_d_rdata} !== 18'h20000) $display("FAIL d48_no_alias: got %h want 20000", {b_d_rvalid, b_addr_err, b_d_rdata}); else n_pass++;
    b_cycle(1'b1, 6'd47, 1'b0, 1'b0, 6'd0, 16'd0);
    b_cycle(1'b1, 6'd60, 1'b0, 1'b0, 6'd0, 16'd0);
    n_chk++;
    if ({b_if_rvalid, b_addr_err, b_if_rdata} !== 18'h30000) $display("FAIL d48_oob_fetch: got %h want 30000", {b_if_rvalid, b_addr_err, b_if_rdata}); else n_pass++;
    b_cycle(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 16'd0);
    n_chk++;
    if (b_addr_err !== 1'b0) $display("FAIL d48_err_pulse: got %b want 0", b_addr_err); else n_pass++;
  endtask
  initial begin
    proc_rst = 1'b0; boot_valid = 1'b0; boot_last = 1'b0; boot_addr = '0; boot_data = '0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    b_rst = 1'b0; b_bv = 1'b0; b_bl = 1'b0; b_ba = '0; b_bd = '0;
    b_ir = 1'b0; b_ia = '0; b_dr = 1'b0; b_dw = 1'b0; b_dbe = '0; b_da = '0; b_dwd = '0;
    test_reset();
    test_boot();
    test_clear_all();
    test_byte_lane();
    test_priority();
    test_back_to_back();
    test_mid_boot_reset();
    test_out_of_range();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
